// File: rtl/bus_master_tx_multi.sv
// Serial transmit port for a system-bus master: arbitration, slave select, header,
// then per-beat write data or a read wait, with retry on slave timeout and abort on grant loss.
module bus_master_tx_multi #(
    parameter int SLAVE_LEN = 2,
    parameter int ADDR_LEN  = 12,
    parameter int DATA_LEN  = 8,
    parameter int BURST_LEN = 12,
    parameter int LANES     = 1,
    parameter int TIMEOUT   = 10,
    parameter int MAX_RETRY = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  logic [SLAVE_LEN-1:0] req_slave,
    input  logic [ADDR_LEN-1:0]  req_addr,
    input  logic [BURST_LEN-1:0] req_burst,
    input  logic [DATA_LEN-1:0]  wdata,
    input  logic                 wdata_valid,
    output logic                 wdata_ready,
    input  logic                 arb_grant,
    input  logic                 bus_busy,
    input  logic                 slave_ready,
    input  logic                 rx_done,
    output logic                 arb_req,
    output logic [LANES-1:0]     tx_slave,
    output logic [LANES-1:0]     tx_addr,
    output logic [LANES-1:0]     tx_burst,
    output logic [LANES-1:0]     tx_data,
    output logic                 m_valid,
    output logic                 write_en,
    output logic                 read_en,
    output logic                 tx_done,
    output logic                 err
);

    // state    | meaning
    // S_IDLE   | ready for a request
    // S_REQ    | arb_req high, waiting for arb_grant
    // S_GNT    | one settling cycle after grant
    // S_SEL    | shifting slave id
    // S_WAIT   | waiting for slave_ready (timeout down-counter)
    // S_RETRY  | arb_req dropped for one cycle before re-request
    // S_HDR    | shifting address and burst count together
    // S_DATA   | per-beat marker then data slices
    // S_RDW    | read issued, waiting for rx_done
    typedef enum logic [3:0] {
        S_IDLE, S_REQ, S_GNT, S_SEL, S_WAIT, S_RETRY, S_HDR, S_DATA, S_RDW
    } state_t;

    localparam int SLV_CYC   = (SLAVE_LEN + LANES - 1) / LANES;
    localparam int ADDR_CYC  = (ADDR_LEN + LANES - 1) / LANES;
    localparam int BURST_CYC = (BURST_LEN + LANES - 1) / LANES;
    localparam int DATA_CYC  = (DATA_LEN + LANES - 1) / LANES;
    localparam int HDR_CYC   = (ADDR_CYC > BURST_CYC) ? ADDR_CYC : BURST_CYC;
    localparam int MAXC_A    = (HDR_CYC > SLV_CYC) ? HDR_CYC : SLV_CYC;
    localparam int MAXC      = (MAXC_A > DATA_CYC) ? MAXC_A : DATA_CYC;
    localparam int PW        = MAXC * LANES;
    localparam int CW        = $clog2(MAXC + 1);
    localparam int WW        = $clog2(TIMEOUT + 2);
    localparam int RW        = $clog2(MAX_RETRY + 2);

    localparam logic [CW-1:0] SLV_LAST   = CW'(SLV_CYC - 1);
    localparam logic [CW-1:0] HDR_LAST   = CW'(HDR_CYC - 1);
    localparam logic [CW-1:0] DATA_LAST  = CW'(DATA_CYC - 1);
    localparam logic [WW-1:0] WAIT_INIT  = WW'(TIMEOUT);
    localparam logic [RW-1:0] RETRY_LAST = RW'(MAX_RETRY);

    // Fields are zero-extended first, so the top slice's unused lanes read as 0.
    function automatic logic [LANES-1:0] take(input logic [PW-1:0] v, input int idx);
        logic [PW-1:0] s;
        s = v >> (idx * LANES);
        return s[LANES-1:0];
    endfunction

    state_t               state_q, state_d;
    logic                 write_q, write_d;
    logic [SLAVE_LEN-1:0] slave_q, slave_d;
    logic [ADDR_LEN-1:0]  addr_q, addr_d;
    logic [BURST_LEN-1:0] burst_q, burst_d;
    logic [DATA_LEN-1:0]  wdata_q, wdata_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [WW-1:0]        wait_q, wait_d;
    logic [RW-1:0]        retry_q, retry_d;
    logic [BURST_LEN-1:0] beats_q, beats_d;
    logic                 in_data_q, in_data_d;
    logic                 arb_req_q, arb_req_d;
    logic [LANES-1:0]     tx_slave_q, tx_slave_d;
    logic [LANES-1:0]     tx_addr_q, tx_addr_d;
    logic [LANES-1:0]     tx_burst_q, tx_burst_d;
    logic [LANES-1:0]     tx_data_q, tx_data_d;
    logic                 write_en_q, write_en_d;
    logic                 read_en_q, read_en_d;
    logic                 tx_done_q, tx_done_d;
    logic                 err_q, err_d;
    logic                 beat_take;
    logic                 go_idle;

    always_comb begin
        state_d    = state_q;
        write_d    = write_q;
        slave_d    = slave_q;
        addr_d     = addr_q;
        burst_d    = burst_q;
        wdata_d    = wdata_q;
        cnt_d      = cnt_q;
        wait_d     = wait_q;
        retry_d    = retry_q;
        beats_d    = beats_q;
        in_data_d  = in_data_q;
        arb_req_d  = arb_req_q;
        tx_slave_d = tx_slave_q;
        tx_addr_d  = tx_addr_q;
        tx_burst_d = tx_burst_q;
        tx_data_d  = tx_data_q;
        write_en_d = write_en_q;
        read_en_d  = read_en_q;
        tx_done_d  = 1'b0;
        err_d      = 1'b0;
        beat_take  = 1'b0;
        go_idle    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req_valid && !bus_busy) begin
                    write_d   = req_write;
                    slave_d   = req_slave;
                    addr_d    = req_addr;
                    burst_d   = req_burst;
                    arb_req_d = 1'b1;
                    state_d   = S_REQ;
                end
            end
            S_REQ: begin
                if (arb_grant) state_d = S_GNT;
            end
            S_GNT: begin
                cnt_d      = '0;
                tx_slave_d = take(PW'(slave_q), 0);
                state_d    = S_SEL;
            end
            S_SEL: begin
                if (!arb_grant) begin
                    err_d   = 1'b1;
                    go_idle = 1'b1;
                end else if (cnt_q == SLV_LAST) begin
                    tx_slave_d = '0;
                    wait_d     = WAIT_INIT;
                    state_d    = S_WAIT;
                end else begin
                    cnt_d      = cnt_q + 1'b1;
                    tx_slave_d = take(PW'(slave_q), int'(cnt_q) + 1);
                end
            end
            S_WAIT: begin
                if (!arb_grant) begin
                    err_d   = 1'b1;
                    go_idle = 1'b1;
                end else if (slave_ready) begin
                    write_en_d = write_q;
                    read_en_d  = !write_q;
                    cnt_d      = '0;
                    tx_addr_d  = take(PW'(addr_q), 0);
                    tx_burst_d = take(PW'(burst_q), 0);
                    state_d    = S_HDR;
                end else if (wait_q != '0) begin
                    wait_d = wait_q - 1'b1;
                end else if (retry_q == RETRY_LAST) begin
                    err_d   = 1'b1;
                    go_idle = 1'b1;
                end else begin
                    retry_d   = retry_q + 1'b1;
                    arb_req_d = 1'b0;
                    state_d   = S_RETRY;
                end
            end
            S_RETRY: begin
                arb_req_d = 1'b1;
                state_d   = S_REQ;
            end
            S_HDR: begin
                if (!arb_grant) begin
                    err_d   = 1'b1;
                    go_idle = 1'b1;
                end else if (slave_ready) begin
                    if (cnt_q == HDR_LAST) begin
                        tx_addr_d  = '0;
                        tx_burst_d = '0;
                        cnt_d      = '0;
                        in_data_d  = 1'b0;
                        beats_d    = (burst_q == '0) ? '0 : burst_q - 1'b1;
                        state_d    = write_q ? S_DATA : S_RDW;
                    end else begin
                        cnt_d      = cnt_q + 1'b1;
                        tx_addr_d  = take(PW'(addr_q), int'(cnt_q) + 1);
                        tx_burst_d = take(PW'(burst_q), int'(cnt_q) + 1);
                    end
                end
            end
            S_DATA: begin
                if (!arb_grant) begin
                    err_d   = 1'b1;
                    go_idle = 1'b1;
                end else if (!in_data_q) begin
                    // Marker cycle: consume one word, data slices follow.
                    if (wdata_valid && slave_ready) begin
                        beat_take = 1'b1;
                        wdata_d   = wdata;
                        in_data_d = 1'b1;
                        cnt_d     = '0;
                        tx_data_d = take(PW'(wdata), 0);
                    end
                end else if (slave_ready) begin
                    if (cnt_q == DATA_LAST) begin
                        tx_data_d = '0;
                        in_data_d = 1'b0;
                        if (beats_q == '0) begin
                            tx_done_d = 1'b1;
                            go_idle   = 1'b1;
                        end else begin
                            beats_d = beats_q - 1'b1;
                        end
                    end else begin
                        cnt_d     = cnt_q + 1'b1;
                        tx_data_d = take(PW'(wdata_q), int'(cnt_q) + 1);
                    end
                end
            end
            S_RDW: begin
                if (!arb_grant) begin
                    err_d   = 1'b1;
                    go_idle = 1'b1;
                end else if (rx_done) begin
                    tx_done_d = 1'b1;
                    go_idle   = 1'b1;
                end
            end
            default: go_idle = 1'b1;
        endcase

        if (go_idle) begin
            state_d    = S_IDLE;
            arb_req_d  = 1'b0;
            write_en_d = 1'b0;
            read_en_d  = 1'b0;
            tx_slave_d = '0;
            tx_addr_d  = '0;
            tx_burst_d = '0;
            tx_data_d  = '0;
            retry_d    = '0;
            in_data_d  = 1'b0;
            cnt_d      = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            write_q    <= 1'b0;
            slave_q    <= '0;
            addr_q     <= '0;
            burst_q    <= '0;
            wdata_q    <= '0;
            cnt_q      <= '0;
            wait_q     <= '0;
            retry_q    <= '0;
            beats_q    <= '0;
            in_data_q  <= 1'b0;
            arb_req_q  <= 1'b0;
            tx_slave_q <= '0;
            tx_addr_q  <= '0;
            tx_burst_q <= '0;
            tx_data_q  <= '0;
            write_en_q <= 1'b0;
            read_en_q  <= 1'b0;
            tx_done_q  <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            write_q    <= write_d;
            slave_q    <= slave_d;
            addr_q     <= addr_d;
            burst_q    <= burst_d;
            wdata_q    <= wdata_d;
            cnt_q      <= cnt_d;
            wait_q     <= wait_d;
            retry_q    <= retry_d;
            beats_q    <= beats_d;
            in_data_q  <= in_data_d;
            arb_req_q  <= arb_req_d;
            tx_slave_q <= tx_slave_d;
            tx_addr_q  <= tx_addr_d;
            tx_burst_q <= tx_burst_d;
            tx_data_q  <= tx_data_d;
            write_en_q <= write_en_d;
            read_en_q  <= read_en_d;
            tx_done_q  <= tx_done_d;
            err_q      <= err_d;
        end
    end

    assign req_ready   = (state_q == S_IDLE);
    assign wdata_ready = beat_take;
    assign m_valid     = beat_take;
    assign arb_req     = arb_req_q;
    assign tx_slave    = tx_slave_q;
    assign tx_addr     = tx_addr_q;
    assign tx_burst    = tx_burst_q;
    assign tx_data     = tx_data_q;
    assign write_en    = write_en_q;
    assign read_en     = read_en_q;
    assign tx_done     = tx_done_q;
    assign err         = err_q;

endmodule

// File: doc/bus_master_tx_multi.md
Name: bus_master_tx_multi

Overview:
- Parametrised serial transmit port for a system-bus master, successor to the single-lane master-out port.
- Accepts a request via valid/ready handshake, then runs the sequence: arbiter request, slave select, slave-ready wait, header, then write data or read wait.
- Additions over the previous generation: LANES-wide serial lanes, a per-beat write-data stream (distinct data per burst beat), pause/resume on slave_ready drop, timeout with bounded retry, and grant-loss abort.
- Sits between the user-side request logic and the arbiter/slave bus; pairs with the master-in receive port through rx_done.

Parameters:
- SLAVE_LEN, 2, slave-select field width
- ADDR_LEN, 12, address field width
- DATA_LEN, 8, data word width
- BURST_LEN, 12, burst-count field width
- LANES, 1, bits shifted per cycle on each serial line (1..8)
- TIMEOUT, 10, cycles to wait for slave_ready before giving up an attempt
- MAX_RETRY, 3, retries after a timeout before reporting an error

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid&&req_ready
- req_write  in  1  1=write, 0=read
- req_slave  in  SLAVE_LEN  target slave id
- req_addr  in  ADDR_LEN  start address
- req_burst  in  BURST_LEN  beat count; 0 means single beat
- wdata  in  DATA_LEN  write word for the current beat
- wdata_valid  in  1  wdata present
- wdata_ready  out  1  beat word consumed this cycle
- arb_grant  in  1  arbiter grant
- bus_busy  in  1  another master owns the bus
- slave_ready  in  1  slave ready
- rx_done  in  1  read completion from master-in port
- arb_req  out  1  bus request to arbiter
- tx_slave  out  LANES  serial slave id
- tx_addr  out  LANES  serial address
- tx_burst  out  LANES  serial burst count
- tx_data  out  LANES  serial write data
- m_valid  out  1  beat marker
- write_en  out  1  write transaction active
- read_en  out  1  read transaction active
- tx_done  out  1  one-cycle completion pulse
- err  out  1  one-cycle failure pulse

Behaviour:
- Reset: state IDLE; every registered output 0; retry count 0; all latches cleared. req_ready = (state==IDLE) combinationally, so it is 1 immediately after reset.
- Serialisation: LSB first, LANES bits per cycle. A W-bit field takes ceil(W/LANES) cycles; unused upper lanes of the last slice are driven 0. Serial lines are 0 outside their active cycles.
- IDLE:
  - On req_valid && !bus_busy: latch req_*, set arb_req=1 next cycle, go to REQ.
  - bus_busy=1 blocks acceptance (req_ready stays 1, but no capture).
- REQ: on arb_grant, wait one further cycle, then go to SEL.
- SEL: shift req_slave on tx_slave, then go to WAIT_SLV with the wait counter cleared.
- WAIT_SLV:
  - slave_ready=1: assert write_en or read_en (held until IDLE), go to HDR.
  - Otherwise increment the wait counter. When it exceeds TIMEOUT: drop arb_req, increment retry, go back to REQ with arb_req reasserted one cycle later.
  - If retry would exceed MAX_RETRY: pulse err, go to IDLE.
- HDR: tx_addr and tx_burst shift concurrently; length = max(ceil(ADDR_LEN/LANES), ceil(BURST_LEN/LANES)). Next state is DATA for writes, RD_WAIT for reads.
- DATA (beats = max(req_burst,1)): each beat has one marker cycle followed by ceil(DATA_LEN/LANES) data cycles.
  - Marker cycle requires wdata_valid: wdata_ready=1 and m_valid=1 for that single cycle, and wdata is captured.
  - If wdata_valid=0, stall with no marker.
  - After the last beat: pulse tx_done, go to IDLE.
- RD_WAIT: on rx_done, pulse tx_done, go to IDLE. There is no timeout in this state.
- Pause: slave_ready=0 in HDR or DATA freezes shift counters and holds serial outputs at their current value; shifting resumes on the same bit when slave_ready returns. Pauses never trigger a timeout.
- Grant loss: arb_grant=0 in SEL, WAIT_SLV, HDR, DATA or RD_WAIT causes an err pulse, all outputs cleared, and a return to IDLE. The request is not retried.
- Leaving to IDLE: arb_req, write_en and read_en clear; the retry count clears.
- Reset mid-transaction returns to IDLE immediately, with outputs as listed under Reset.

Test Plan:
- Write, LANES=1, addr=0x5A3, burst=0, wdata=0xC4 → 12 header cycles; one m_valid cycle; tx_data serialises 0,0,1,0,0,0,1,1; tx_done pulses once; arb_req falls the next cycle.
- Write, LANES=4, burst=3, wdata stream 0x11,0x22,0x33 → header 3 cycles; three beats of 1 marker + 2 data cycles; exactly 3 wdata_ready pulses; tx_done pulses.
- Read, addr=0x0FF, burst=2 → read_en=1; header sent; outputs hold until rx_done; tx_done pulses the cycle after rx_done.
- slave_ready low for 11 cycles in WAIT_SLV on every attempt → 4 arb_req attempts, then a single err pulse and IDLE; no tx_done.
- slave_ready drops for 5 cycles mid-data → tx_data holds its bit; the remaining bits resume unchanged; total data cycles are unchanged.
- arb_grant drops during HDR → err pulses, write_en=0, state IDLE; a new request with bus_busy=1 is not accepted.
